// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM and a
// single-entry holding register presented on a valid/ready write port.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             rx_s1, rx_s2;
    logic             commit, ferr_n;
    logic             load, ovr_n, hs;

    // Pin synchroniser; resets to the idle (mark) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        idx_n   = idx;
        shreg_n = shreg;
        commit  = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s2) state_n = START;
            end
            START: begin
                // Re-check the start bit at its centre to reject glitches.
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s2, shreg[7:1]};
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (rx_s2) begin
                        commit  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not look like a new start bit.
                cnt_n = '0;
                if (rx_s2) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign hs    = rx_valid && rx_ready;
    assign load  = commit && (!rx_valid || rx_ready);
    assign ovr_n = commit && rx_valid && !rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_n;
            overrun   <= ovr_n;
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (hs) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default 50 MHz / 115200 baud.
module tb_uart_rx;

    localparam int C   = 434;
    localparam int LAT = 4126;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int n_chk = 0;
    int n_err = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int ov_cyc = 0;
    int n_rise = 0;
    int n_fe = 0;
    int n_ov = 0;
    int n_both = 0;
    int vhold = 0;
    int ready_mode = 1;
    logic vld_d = 1'b0;
    logic [7:0] got_q[$];

    uart_rx dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_valid && !vld_d) begin
            rise_cyc <= cyc;
            n_rise   <= n_rise + 1;
        end
        vld_d <= rx_valid;
        if (frame_err) n_fe <= n_fe + 1;
        if (overrun) begin
            n_ov   <= n_ov + 1;
            ov_cyc <= cyc;
        end
        if (frame_err && overrun) n_both <= n_both + 1;
        vhold <= rx_valid ? vhold + 1 : 0;
    end

    // 0: ready low, 1: ready high, 2: random but forced high after ~250 cycles held.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = (vhold > 250) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #(160_000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 exactly where the next start bit may begin.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int nstop);
        rx = 1'b0;
        fall_cyc = cyc;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(C);
        end
        rx = stop_v;
        tick(nstop * C);
        if (!stop_v) begin
            rx = 1'b1;
            tick(C);
        end
    endtask

    function automatic logic in_tol(input int d, input int target);
        return (d >= target - 1) && (d <= target + 1);
    endfunction

    initial begin
        int q0, r0, fe0, ov0, lat;

        rst = 1'b1;
        tick(3);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data",  32'(rx_data),  32'h00);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_ovr",   32'(overrun),  32'd0);
        rst = 1'b0;
        tick(5);

        // Single byte with consumer always ready.
        q0 = got_q.size(); r0 = n_rise; fe0 = n_fe; ov0 = n_ov;
        send_frame(8'h11, 1'b1, 1);
        tick(10);
        lat = rise_cyc - fall_cyc;
        if (!in_tol(lat, LAT)) $display("latency measured %0d", lat);
        check("single_lat_ok", 32'(in_tol(lat, LAT)), 32'd1);
        check("single_cnt",  32'(got_q.size() - q0), 32'd1);
        check("single_data", 32'(got_q[q0]), 32'h11);
        check("single_rise", 32'(n_rise - r0), 32'd1);
        check("single_ferr", 32'(n_fe - fe0), 32'd0);
        check("single_ovr",  32'(n_ov - ov0), 32'd0);
        check("single_busy", 32'(busy), 32'd0);

        // Back-to-back burst with a randomly stalling consumer.
        ready_mode = 2;
        q0 = got_q.size(); ov0 = n_ov;
        for (int k = 0; k < 5; k++) send_frame(8'h11 + 8'(k), 1'b1, 1);
        tick(400);
        ready_mode = 1;
        tick(5);
        check("burst_cnt", 32'(got_q.size() - q0), 32'd5);
        for (int k = 0; k < 5; k++)
            if (q0 + k < got_q.size())
                check($sformatf("burst_data%0d", k), 32'(got_q[q0+k]), 32'h11 + 32'(k));
        check("burst_ovr", 32'(n_ov - ov0), 32'd0);

        // Short low glitch is rejected at the start-bit centre.
        r0 = n_rise; fe0 = n_fe;
        rx = 1'b0;
        tick(100);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        tick(300);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_rise", 32'(n_rise - r0), 32'd0);
        check("glitch_ferr", 32'(n_fe - fe0), 32'd0);

        // Stop bit held low for two bit times, then a good frame.
        q0 = got_q.size(); r0 = n_rise; fe0 = n_fe;
        send_frame(8'hA5, 1'b0, 2);
        check("frm_ferr", 32'(n_fe - fe0), 32'd1);
        check("frm_rise", 32'(n_rise - r0), 32'd0);
        send_frame(8'h3C, 1'b1, 1);
        tick(10);
        check("frm_cnt",  32'(got_q.size() - q0), 32'd1);
        check("frm_data", 32'(got_q[q0]), 32'h3C);
        check("frm_ferr_total", 32'(n_fe - fe0), 32'd1);

        // Overrun: second byte dropped while the first is held.
        ready_mode = 0;
        tick(2);
        q0 = got_q.size(); ov0 = n_ov;
        send_frame(8'hA5, 1'b1, 1);
        send_frame(8'h5A, 1'b1, 1);
        tick(10);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data",  32'(rx_data), 32'hA5);
        check("ovr_pulse", 32'(n_ov - ov0), 32'd1);
        check("ovr_time_ok", 32'(in_tol(ov_cyc - fall_cyc, LAT)), 32'd1);
        ready_mode = 1;
        tick(10);
        check("ovr_cnt",  32'(got_q.size() - q0), 32'd1);
        check("ovr_first", 32'(got_q[q0]), 32'hA5);
        check("ovr_drained", 32'(rx_valid), 32'd0);

        // Reset during the data bits of 0xF0 with a byte pending.
        ready_mode = 0;
        tick(2);
        fe0 = n_fe; ov0 = n_ov;
        send_frame(8'h77, 1'b1, 1);
        tick(2);
        check("pend_valid", 32'(rx_valid), 32'd1);
        fork
            send_frame(8'hF0, 1'b1, 1);
            begin
                tick(C * 6 + C / 2);
                check("mid_busy", 32'(busy), 32'd1);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                check("mrst_valid", 32'(rx_valid), 32'd0);
                check("mrst_data",  32'(rx_data),  32'h00);
                check("mrst_busy",  32'(busy),     32'd0);
                check("mrst_ferr",  32'(frame_err), 32'd0);
                check("mrst_ovr",   32'(overrun),  32'd0);
            end
        join
        ready_mode = 1;
        q0 = got_q.size();
        tick(5);
        check("mrst_lost", 32'(got_q.size() - q0), 32'd0);
        send_frame(8'h0F, 1'b1, 1);
        tick(10);
        check("mrst_cnt",  32'(got_q.size() - q0), 32'd1);
        check("mrst_next", 32'(got_q[q0]), 32'h0F);
        check("mrst_flags", 32'((n_fe - fe0) + (n_ov - ov0)), 32'd0);
        check("no_coincident_flags", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
